// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD <-> binary converters: default digit count and
// binary width, FSM state encoding, iteration-counter width and a digit check.
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int DEF_DIGITS = 6;
  localparam int DEF_BIN_W  = 20;   // 20 bits holds 999999

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // The counter runs 0 .. bin_w-1, so it needs clog2(bin_w) bits (at least 1).
  function automatic int cnt_width(input int bin_w);
    int w;
    w = $clog2(bin_w);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_BIN_W);

  // True when the nibble is a legal decimal digit.
  function automatic logic is_bcd_digit(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// -----------------------------------------------------------------------------
// bcd_nibble_adjust
// Combinational correction cell for reverse double-dabble: a nibble that is
// >= 8 after the right shift has 3 subtracted, otherwise it passes through.
// Ports:
//   nib_in  [3:0] : shifted BCD nibble
//   nib_out [3:0] : corrected nibble
// -----------------------------------------------------------------------------
module bcd_nibble_adjust (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  // Subtract 3 from nibbles >= 8; the result is never negative since 8-3 = 5.
  always_comb begin
    if (nib_in >= 4'd8) begin
      nib_out = nib_in - 4'd3;
    end else begin
      nib_out = nib_in;
    end
  end

endmodule

// File: rtl/bcd_to_bin_converter.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_converter
// Sequential packed-BCD to binary converter using reverse double-dabble, one
// iteration per clock. Illegal digits (> 9) short-circuit straight to DONE with
// err set and a zero result.
// Ports:
//   clock          : system clock, rising edge
//   reset          : asynchronous, active-high
//   start          : conversion request, accepted in IDLE or DONE
//   bcd_in  [4*DIGITS-1:0] : packed BCD, MS digit in top nibble
//   bin_out [BIN_W-1:0]    : registered binary result
//   busy           : high while iterating
//   done           : one-cycle pulse, bin_out/err valid
//   err            : last accepted input contained an illegal digit
// -----------------------------------------------------------------------------
module bcd_to_bin_converter
  import bcd_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_e              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [WORK_W-1:0]   work_shift_s;
  logic [BCD_W-1:0]    bcd_adj_s;
  logic [WORK_W-1:0]   work_iter_s;
  logic                bcd_ok_s;

  // The BCD field shifts its LSB into the top of the binary field each step.
  assign work_shift_s = work_q >> 1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_nibble_adjust u_adj (
        .nib_in  (work_shift_s[BIN_W + 4*g +: 4]),
        .nib_out (bcd_adj_s[4*g +: 4])
      );
    end
  endgenerate

  assign work_iter_s = {bcd_adj_s, work_shift_s[BIN_W-1:0]};

  // Input legality: every nibble of bcd_in must be 0..9.
  always_comb begin
    bcd_ok_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(bcd_in[4*i +: 4])) begin
        bcd_ok_s = 1'b0;
      end else begin
        bcd_ok_s = bcd_ok_s;
      end
    end
  end

  // Next-state and next-output logic for the converter FSM.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_d = {CNT_W{1'b0}};
          if (bcd_ok_s) begin
            state_d = ST_SHIFT;
            work_d  = {bcd_in, {BIN_W{1'b0}}};
            busy_d  = 1'b1;
          end else begin
            // Illegal digit: report immediately without iterating.
            state_d = ST_DONE;
            bin_d   = {BIN_W{1'b0}};
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        work_d = work_iter_s;
        if (cnt_q == LAST_ITER) begin
          // Final iteration: publish the binary field of this step's result.
          state_d = ST_DONE;
          bin_d   = work_iter_s[BIN_W-1:0];
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= {WORK_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      bin_q   <= {BIN_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin_converter
// Self-checking bench: directed corner cases plus randomized packed-BCD inputs,
// compared against a decimal-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin_converter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [23:0] bcd_in;
  logic [19:0] bin_out;
  logic        busy;
  logic        done;
  logic        err;

  int total;
  int bad;

  bcd_to_bin_converter #(.DIGITS(6), .BIN_W(20)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Decimal value of the packed digits; flags any digit above 9.
  task automatic ref_conv(input logic [23:0] bcd, output int val, output bit illegal);
    int d;
    int weight;
    val = 0;
    illegal = 1'b0;
    weight = 1;
    for (int i = 0; i < 6; i++) begin
      d = int'((bcd >> (4 * i)) & 24'hF);
      if (d > 9) illegal = 1'b1;
      val += d * weight;
      weight *= 10;
    end
    if (illegal) val = 0;
  endtask

  // Issue one conversion, optionally poke start again mid-run, check result.
  task automatic run_conv(input string tag, input logic [23:0] bcd,
                          input bit post_chk, input int inject_at);
    int  exp_v;
    bit  exp_bad;
    int  lat;
    int  busy_n;
    ref_conv(bcd, exp_v, exp_bad);
    start  = 1'b1;
    bcd_in = bcd;
    tick();
    start  = 1'b0;
    bcd_in = $urandom;
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      if (lat == inject_at) begin
        start  = 1'b1;
        bcd_in = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check_val({tag, ".lat"},  lat,     exp_bad ? 0 : 20);
    check_val({tag, ".busy"}, busy_n,  exp_bad ? 0 : 20);
    check_val({tag, ".bin"},  bin_out, exp_v);
    check_val({tag, ".err"},  err,     exp_bad);
    if (post_chk) begin
      tick();
      check_val({tag, ".done_low"}, done,    1'b0);
      check_val({tag, ".hold_bin"}, bin_out, exp_v);
      check_val({tag, ".hold_err"}, err,     exp_bad);
    end
  endtask

  initial begin
    int done_seen;
    logic [23:0] rnd;
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = 24'h0;
    tick();
    tick();
    check_val("rst.bin",  bin_out, 0);
    check_val("rst.busy", busy,    0);
    check_val("rst.done", done,    0);
    check_val("rst.err",  err,     0);
    reset = 1'b0;

    run_conv("zero",   24'h000000, 1'b1, -1);
    run_conv("nines",  24'h999999, 1'b1, -1);
    run_conv("12345",  24'h012345, 1'b1, -1);
    run_conv("illeg",  24'h00A000, 1'b1, -1);
    run_conv("inject", 24'h987654, 1'b1, 5);

    // Reset in the middle of iterating.
    run_conv("pre_rst", 24'h054321, 1'b1, -1);
    start  = 1'b1;
    bcd_in = 24'h999999;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check_val("midrst.bin",  bin_out, 0);
    check_val("midrst.busy", busy,    0);
    check_val("midrst.done", done,    0);
    check_val("midrst.err",  err,     0);
    tick();
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) done_seen++;
      tick();
    end
    check_val("midrst.no_done", done_seen, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_conv("after_rst", 24'h000042, 1'b1, -1);

    // Back-to-back: start already high in the DONE cycle.
    run_conv("b2b_a", 24'h000007, 1'b0, -1);
    run_conv("b2b_b", 24'h100000, 1'b1, -1);

    // Randomized: mix of legal and illegal inputs, gaps and chained starts.
    for (int n = 0; n < 40; n++) begin
      rnd = 24'h0;
      for (int i = 0; i < 6; i++) begin
        rnd[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 4) == 0) begin
        rnd[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
      end
      run_conv("rand", rnd, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : -1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_converter.md
BCD_TO_BIN_CONVERTER -- requirements
Module: bcd_to_bin_converter

Interface
REQ-001 SHALL have parameter DIGITS, default 6, the number of packed BCD digits in bcd_in.
REQ-002 SHALL have parameter BIN_W, default 20, the width of bin_out; 20 bits covers 999999.
REQ-003 SHALL have port clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, a conversion request sampled when the block is not busy.
REQ-006 SHALL have port bcd_in, input, 4*DIGITS, packed BCD with the most significant digit in the top nibble.
REQ-007 SHALL have port bin_out, output, BIN_W, the registered binary result.
REQ-008 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse marking bin_out/err valid.
REQ-010 SHALL have port err, output, 1, high when the last accepted bcd_in held a digit greater than 9.

Function
REQ-011 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-012 SHALL accept start in IDLE or DONE only, capturing bcd_in at that edge (edge N); start while busy is ignored and bcd_in changes after capture have no effect.
REQ-013 SHALL, at edge N with every digit <= 9, load a working register of {bcd_in, BIN_W zeros}, clear the iteration counter and enter SHIFT.
REQ-014 SHALL, in SHIFT, perform one reverse double-dabble iteration per cycle: shift the working register right 1 bit, then subtract 3 from every BCD nibble whose value is >= 8.
REQ-015 SHALL run exactly BIN_W iterations and enter DONE at edge N+BIN_W; the counter SHALL saturate and not wrap.
REQ-016 SHALL hold busy = 1 from edge N through edge N+BIN_W, i.e. for exactly BIN_W cycles.
REQ-017 SHALL, on entry to DONE, load bin_out from the low BIN_W bits of the working register with err = 0, and assert done for that single cycle.
REQ-018 SHALL, at edge N with any digit > 9, skip SHIFT, enter DONE directly with bin_out = 0 and err = 1, and assert done in the cycle after edge N.
REQ-019 SHALL return from DONE to IDLE after one cycle unless start is high, in which case a new conversion begins (back-to-back operation, no bubble).
REQ-020 SHALL hold bin_out and err stable from the done pulse until the next done pulse.
REQ-021 SHALL keep all arithmetic unsigned; nibble subtraction SHALL never underflow for valid input.

Reset
REQ-022 SHALL, on reset assertion at any time including mid-SHIFT, immediately enter IDLE with bin_out = 0, busy = 0, done = 0, err = 0, and clear the counter and working register.
REQ-023 SHALL NOT produce a done pulse for a conversion aborted by reset; start SHALL be honoured from the first rising edge after reset deasserts.

Structure
REQ-024 SHALL place DIGITS and BIN_W defaults, the state encoding and the iteration-counter width in a shared package, bcd_pkg, reused with the binary-to-BCD scorer.
REQ-025 SHALL use one sub-module, bcd_nibble_adjust, as a combinational 4-bit ">= 8 then subtract 3" cell instantiated DIGITS times; the FSM, counter and registers SHALL remain in the top level.

Verification
REQ-026 SHALL cover: start with bcd_in = 24'h000000 -> done 20 cycles after the capture edge, bin_out = 0, err = 0.
REQ-027 SHALL cover: bcd_in = 24'h999999 -> bin_out = 20'hF423F (999999), err = 0; and 24'h012345 -> bin_out = 20'h03039.
REQ-028 SHALL cover: bcd_in = 24'h00A000 -> done on the next cycle, err = 1, bin_out = 0, busy never high.
REQ-029 SHALL cover: start pulsed again at cycle 5 of a conversion with different bcd_in -> ignored, the first result is delivered unchanged.
REQ-030 SHALL cover: reset asserted at iteration 10 -> all outputs are 0 immediately, no done pulse; a fresh 24'h000042 conversion afterwards yields 20'h0002A.
REQ-031 SHALL cover: start held high during DONE with a new 24'h100000 -> the next done arrives 20 cycles later with bin_out = 20'h186A0.
